// File: rtl/if_id_pkg.sv
// Shared fetch/decode types for the IF/ID queue.
// The entry struct and the no-exception code are shared with the fetch and decode stages.
package if_id_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        delay_slot;
    logic [31:0] exc_type;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID queue.
// slave = queue side, master = fetch/decode environment side.
interface if_id_queue_if #(
  parameter int AW = 2
);
  import if_id_pkg::*;

  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        delay_slot_f;
  logic [31:0] exc_type_f;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] pc_plus8_d;
  logic        in_delay_slot_d;
  logic [31:0] exc_type_d;
  logic [AW:0] count;

  modport slave (
    input  flush, push_valid, instr_f, pc_f,
    input  delay_slot_f, exc_type_f, pop_ready,
    output push_ready, pop_valid, instr_d, pc_d,
    output pc_plus4_d, pc_plus8_d,
    output in_delay_slot_d, exc_type_d, count
  );

  modport master (
    output flush, push_valid, instr_f, pc_f,
    output delay_slot_f, exc_type_f, pop_ready,
    input  push_ready, pop_valid, instr_d, pc_d,
    input  pc_plus4_d, pc_plus8_d,
    input  in_delay_slot_d, exc_type_d, count
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue.
// One synchronous write port, one asynchronous read port, no reset.
module if_id_queue_mem
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  // Write the pushed entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID circular queue: pointers, count, handshake and head output mux.
// Optional same-cycle empty bypass under macro IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  if_id_queue_if.slave  bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, push_ready, byp;
  logic          push_fire, pop_fire;
  fetch_entry_t  wr_entry, head, out_e;

  assign empty      = (cnt_q == '0);
  assign push_ready = (cnt_q != FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = rst & empty & bus.push_valid
             & bus.pop_ready & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  assign push_fire = bus.push_valid & push_ready
                   & ~byp & ~bus.flush;
  assign pop_fire  = ~empty & bus.pop_ready & ~bus.flush;

  assign wr_entry.instr      = bus.instr_f;
  assign wr_entry.pc         = bus.pc_f;
  assign wr_entry.delay_slot = bus.delay_slot_f;
  assign wr_entry.exc_type   = bus.exc_type_f;

  // Next pointers and count; flush wins over both handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_fire, pop_fire})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Head entry when stored, fetch inputs on bypass, else zero.
  always_comb begin
    out_e          = '0;
    out_e.exc_type = EXC_NONE;
    unique case (1'b1)
      ~empty:  out_e = head;
      byp:     out_e = wr_entry;
      default: ;
    endcase
  end

  assign bus.push_ready      = push_ready;
  assign bus.pop_valid       = ~empty | byp;
  assign bus.instr_d         = out_e.instr;
  assign bus.pc_d            = out_e.pc;
  assign bus.in_delay_slot_d = out_e.delay_slot;
  assign bus.exc_type_d      = out_e.exc_type;
  assign bus.pc_plus4_d      = bus.pop_valid ? out_e.pc + 32'd4 : '0;
  assign bus.pc_plus8_d      = bus.pop_valid ? out_e.pc + 32'd8 : '0;
  assign bus.count           = cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model,
// per-cycle compare process, directed scenarios and random traffic.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_queue_if #(.AW(2)) bus();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b1;
  fetch_entry_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fetch_entry_t in_entry();
    fetch_entry_t e;
    e.instr      = bus.instr_f;
    e.pc         = bus.pc_f;
    e.delay_slot = bus.delay_slot_f;
    e.exc_type   = bus.exc_type_f;
    return e;
  endfunction

  // Reference model: a plain FIFO of entries.
  always @(posedge clk or negedge rst) begin
    int n;
    bit b;
    if (!rst) model_q.delete();
    else if (bus.flush) model_q.delete();
    else begin
      n = model_q.size();
      b = BYP && n == 0 && bus.push_valid && bus.pop_ready;
      if (n != 0 && bus.pop_ready) void'(model_q.pop_front());
      if (bus.push_valid && n != DEPTH && !b) model_q.push_back(in_entry());
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    fetch_entry_t e;
    bit v;
    bit b;
    int n;
    if (cmp_en) begin
      n = model_q.size();
      b = BYP && rst && !bus.flush && n == 0
          && bus.push_valid && bus.pop_ready;
      v = (n != 0) || b;
      e = '0;
      if (n != 0) e = model_q[0];
      else if (b) e = in_entry();
      chk("count", 32'(bus.count), 32'(n));
      chk("push_ready", 32'(bus.push_ready), 32'(n != DEPTH));
      chk("pop_valid", 32'(bus.pop_valid), 32'(v));
      chk("instr_d", bus.instr_d, e.instr);
      chk("pc_d", bus.pc_d, e.pc);
      chk("pc_plus4_d", bus.pc_plus4_d, v ? e.pc + 32'd4 : 32'd0);
      chk("pc_plus8_d", bus.pc_plus8_d, v ? e.pc + 32'd8 : 32'd0);
      chk("dly_d", 32'(bus.in_delay_slot_d), 32'(e.delay_slot));
      chk("exc_d", bus.exc_type_d, e.exc_type);
    end
  end

  task automatic drive(input bit pv, input bit pr, input bit fl,
                       input logic [31:0] pc, input logic [31:0] exc);
    @(posedge clk);
    #1;
    bus.push_valid   = pv;
    bus.pop_ready    = pr;
    bus.flush        = fl;
    bus.pc_f         = pc;
    bus.instr_f      = {pc[15:0], ~pc[15:0]};
    bus.delay_slot_f = pc[3];
    bus.exc_type_f   = exc;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] drain [3];
    logic [31:0] exp_exc;
    drain[0] = 32'h104;
    drain[1] = 32'h108;
    drain[2] = 32'h10C;
    bus.push_valid = 1'b0;
    bus.pop_ready = 1'b0;
    bus.flush = 1'b0;
    bus.pc_f = '0;
    bus.instr_f = '0;
    bus.delay_slot_f = 1'b0;
    bus.exc_type_f = '0;

    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_pc_d", bus.pc_d, 32'd0);
    #1 rst = 1'b1;

    // Three pushes, no pops.
    drive(1, 0, 0, 32'h100, 0);
    drive(1, 0, 0, 32'h104, 0);
    drive(1, 0, 0, 32'h108, 0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_pc_d", bus.pc_d, 32'h100);
    chk("t1_pc4", bus.pc_plus4_d, 32'h104);
    chk("t1_pc8", bus.pc_plus8_d, 32'h108);

    // Fill, hold push, then pop while full.
    drive(1, 0, 0, 32'h10C, 0);
    drive(1, 0, 0, 32'h200, 0);
    sample();
    chk("t2_full_ready", 32'(bus.push_ready), 32'd0);
    chk("t2_full_count", 32'(bus.count), 32'd4);
    drive(1, 1, 0, 32'h204, 0);
    sample();
    chk("t2_pop_ready_full", 32'(bus.push_ready), 32'd0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t2_ready_after_pop", 32'(bus.push_ready), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      sample();
      chk("t2_drain_pc", bus.pc_d, drain[i]);
    end
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t2_empty", 32'(bus.count), 32'd0);

    // Steady push+pop at count 2, wrapping pointers.
    drive(1, 0, 0, 32'h300, 0);
    drive(1, 0, 0, 32'h304, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 32'h308 + 32'(4 * i), 0);
      sample();
      chk("t3_count", 32'(bus.count), 32'd2);
      chk("t3_pc", bus.pc_d, 32'h300 + 32'(4 * i));
    end
    drive(0, 0, 1, 0, 0);

    // Flush together with a push.
    drive(1, 0, 0, 32'h400, 0);
    drive(1, 0, 0, 32'h404, 0);
    drive(1, 0, 0, 32'h408, 0);
    drive(1, 0, 1, 32'h40C, 0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t4_count", 32'(bus.count), 32'd0);
    chk("t4_pop_valid", 32'(bus.pop_valid), 32'd0);

    // Asynchronous reset pulse between edges.
    drive(1, 0, 0, 32'h500, 32'h3);
    drive(1, 0, 0, 32'h504, 0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t5_count_pre", 32'(bus.count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("t5_pc_d", bus.pc_d, 32'd0);
    chk("t5_exc_d", bus.exc_type_d, 32'd0);
    #1 rst = 1'b1;

    // Exception entry into an empty queue with pop_ready high.
    drive(1, 1, 0, 32'h600, 32'h10);
    sample();
    exp_exc = BYP ? 32'h10 : 32'h0;
    chk("t6_pv_same", 32'(bus.pop_valid), 32'(BYP));
    chk("t6_exc_same", bus.exc_type_d, exp_exc);
    drive(0, 0, 0, 0, 0);
    sample();
    exp_exc = BYP ? 32'h0 : 32'h10;
    chk("t6_pv_next", 32'(bus.pop_valid), 32'(!BYP));
    chk("t6_exc_next", bus.exc_type_d, exp_exc);
    drive(0, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 2) != 0,
            ($urandom % 32) == 0, $urandom & 32'hFFFF_FFFC,
            (($urandom % 4) == 0) ? $urandom : 32'h0);
    end
    drive(0, 0, 0, 32'hFFFF_FFFC, 0);
    drive(1, 0, 0, 32'hFFFF_FFFC, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("t7_wrap_pc4", bus.pc_plus4_d, 32'h0);
    chk("t7_wrap_pc8", bus.pc_plus8_d, 32'h4);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width; not overridden by users.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  in  1  synchronous discard of all entries.
REQ-006 SHALL have ports push_valid in 1 and push_ready out 1, the fetch-side handshake.
REQ-007 SHALL have ports instr_f in 32, pc_f in 32, delay_slot_f in 1 and exc_type_f in 32, the fetch-side entry fields.
REQ-008 SHALL have ports pop_valid out 1 and pop_ready in 1, the decode-side handshake.
REQ-009 SHALL have outputs instr_d 32, pc_d 32, pc_plus4_d 32, pc_plus8_d 32, in_delay_slot_d 1 and exc_type_d 32, the head entry.
REQ-010 SHALL have output count, AW+1 bits, number of stored entries.

Function
REQ-011 SHALL store entries in a circular buffer with a write pointer and a read pointer, each wrapping modulo DEPTH.
REQ-012 SHALL accept a push on a rising edge where push_valid and push_ready are both high.
REQ-013 SHALL complete a pop on a rising edge where pop_valid and pop_ready are both high.
REQ-014 SHALL drive push_ready = (count != DEPTH) and pop_valid = (count != 0), both decoded from registers only.
REQ-015 SHALL make a pushed entry visible at the outputs in the cycle after the push: 1-cycle latency.
REQ-016 SHALL drive instr_d, pc_d, in_delay_slot_d and exc_type_d from the head entry when pop_valid is high, and all-zero when the queue is empty.
REQ-017 SHALL compute pc_plus4_d = pc_d+4 and pc_plus8_d = pc_d+8, modulo 2^32, so 0xFFFFFFFC yields 0x00000000 and 0x00000004.
REQ-018 SHALL store exc_type_f unchanged with its entry; an entry carrying an exception is queued and popped like any other.
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL, when full, keep push_ready low even if pop_ready is high; a push is not taken in the same cycle as the pop that frees space.
REQ-021 SHALL, when empty, accept a simultaneous push and leave pop_valid low that cycle.
REQ-022 SHALL, on flush high at a clock edge, set both pointers and count to 0 and ignore that cycle's push and pop.
REQ-023 SHALL give flush priority over all handshakes; pop_valid is low in the cycle after a flush.

Reset
REQ-024 SHALL, on rst low, immediately clear both pointers and count, independent of clk.
REQ-025 SHALL hold, during reset, push_ready=1, pop_valid=0, count=0 and all data outputs at 0.
REQ-026 SHALL discard a push or pop handshake in progress when reset is asserted mid-operation.
REQ-027 SHALL leave storage array contents unreset; no output depends on them while empty.

Configuration
REQ-028 SHALL support macro IF_ID_QUEUE_BYPASS_EN.
REQ-029 SHALL, when the macro is defined and the queue is empty with push_valid, pop_ready high and flush low, drive pop_valid high and the outputs from the fetch-side inputs in the same cycle, without storing the entry or changing count.
REQ-030 SHALL, when the macro is undefined, behave exactly as REQ-015 and REQ-021 with no combinational path from the fetch side to the decode side.

Structure
REQ-031 SHALL take from shared package if_id_pkg the struct fetch_entry_t {instr, pc, delay_slot, exc_type} and the constant EXC_NONE = 32'h0.
REQ-032 SHALL place storage in sub-module if_id_queue_mem: DEPTH x fetch_entry_t, one synchronous write port and one asynchronous read port.
REQ-033 SHALL keep pointer, count and handshake logic in if_id_queue.

Verification
REQ-034 SHALL cover: push pc 0x100, 0x104, 0x108 with pop_ready=0 -> count=3, pc_d=0x100, pc_plus8_d=0x108.
REQ-035 SHALL cover: fill DEPTH=4 and hold push_valid -> push_ready=0; pop once -> push_ready=1 the next cycle and pops return entries in order.
REQ-036 SHALL cover: count=2 with simultaneous push and pop for 10 cycles -> count stays 2; pointers wrap past index 3; data stays in order.
REQ-037 SHALL cover: count=3, flush together with push_valid -> next cycle count=0, pop_valid=0, pushed entry lost.
REQ-038 SHALL cover: rst pulsed low between clock edges with count=2 -> count=0 and outputs zero before the next edge.
REQ-039 SHALL cover: empty queue, push exc_type 0x10 with pop_ready=1 -> pop_valid in the same cycle with the macro defined, the next cycle without it; exc_type_d=0x10.
